exu_alu_sched: RTL and testbench
================================

// Module: exu_alu_sched
// PURPOSE
//  Round-robin scheduler that shares one exu_alu_ctl datapath among NUM_REQ issue requesters.
//  Grants one op per cycle and drives the ALU operand/enable inputs. Returns the ALU result,
//  tagged with the requester id, one cycle later. Honours freeze/flush and response back-pressure.
//  Sits between the decode issue slots and the ALU.
// PARAMETERS
//  NUM_REQ  4                   number of requesters (2..8)
//  OPW      16                  width of the flattened alu_pkt_t op field
//  IDW      $clog2(NUM_REQ)     requester id width (derived, do not override)
// PORTS
//  clk        in   1            core clock
//  rst        in   1            synchronous reset, active-high
//  freeze     in   1            pipeline freeze: no grant, no response, state held
//  flush      in   1            pipeline flush: kill in-flight op
//  req_valid  in   NUM_REQ      per-requester op valid
//  req_ready  out  NUM_REQ      per-requester grant (one-hot or zero)
//  req_a      in   NUM_REQ*32   operand A, requester i at [32*i+:32]
//  req_b      in   NUM_REQ*32   operand B
//  req_pc     in   NUM_REQ*31   pc[31:1]
//  req_op     in   NUM_REQ*OPW  op predecode packet
//  alu_valid  out  1            to ALU valid
//  alu_enable out  1            to ALU operand-flop enable
//  alu_a      out  32           muxed operand A (0 when no grant)
//  alu_b      out  32           muxed operand B (0 when no grant)
//  alu_pc     out  31           muxed pc (0 when no grant)
//  alu_op     out  OPW          muxed op (0 when no grant)
//  alu_flush  out  1            equals flush
//  alu_out    in   32           ALU result, valid the cycle after alu_enable
//  rsp_valid  out  1            result valid
//  rsp_ready  in   1            consumer accepts result
//  rsp_id     out  IDW          requester id of the result
//  rsp_data   out  32           equals alu_out
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  States:
//   - IDLE: ALU empty.
//   - EXEC: op in ALU flops, result presented.
//   - HOLD: result presented, stalled on rsp_ready.
//  can_issue = ~flush & ~freeze & (IDLE | (EXEC|HOLD) & rsp_ready).
//  Grant: when can_issue, grant the first valid requester scanning ptr, ptr+1, ... mod NUM_REQ.
//   - req_ready = grant, driven combinationally; transfer = |(req_valid & req_ready).
//   - alu_valid = alu_enable = transfer; operands are muxed from the granted requester.
//  On transfer: inflight_id <= granted id; ptr <= (id+1) mod NUM_REQ; state <= EXEC.
//  Response: rsp_valid = (EXEC|HOLD) & ~freeze & ~flush; rsp_id = inflight_id.
//  Transitions:
//   - Accept (rsp_valid & rsp_ready) with no transfer: state -> IDLE.
//   - Accept with a transfer in the same cycle: stay EXEC. Back-to-back throughput is 1 op/cycle.
//   - rsp_valid & ~rsp_ready: state -> HOLD. alu_enable = 0, so the ALU flops and alu_out
//     hold stable; no grant.
//  freeze: state, ptr and inflight_id held; alu_enable = 0; rsp_valid = 0. Result is re-presented
//   with the same id after freeze drops.
//  flush: overrides freeze and rsp_ready. state -> IDLE, rsp_valid = 0, no grant that cycle,
//   ptr unchanged. The killed result is never returned.
//  Requesters must hold req_* stable while req_valid & ~req_ready. Latency is 1 cycle from
//   transfer to the first rsp_valid.
//  Reset: state = IDLE, ptr = 0, inflight_id = 0. All outputs 0 during and after reset until
//   the first grant. rst mid-EXEC/HOLD drops the op silently.
// TESTING
//  T1: rst=1 for 2 cycles, all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0. Then rst=0 ->
//      grant[0] in the first cycle.
//  T2: NUM_REQ=4, all valid, rsp_ready=1, req_a=i -> grants 0,1,2,3,0 on consecutive cycles.
//      rsp_id 0,1,2,3 one cycle later; alu_enable held at 1.
//  T3: EXEC with rsp_ready=0 for 3 cycles, req2 valid -> HOLD, rsp_data stable, alu_enable=0,
//      req_ready=0. On rsp_ready=1, accept and grant req2 in the same cycle.
//  T4: flush in EXEC cycle (id=1) -> rsp_valid=0, next state IDLE. Next grant begins at ptr=2
//      and id 1 is never returned.
//  T5: freeze=1 for 2 cycles in EXEC (id=3, alu_out=0x1234) -> no grant, rsp_valid=0. After
//      freeze: rsp_valid=1, rsp_id=3, rsp_data=0x1234.
//  T6: only req1 valid continuously, rsp_ready=1 -> req1 granted every cycle; ptr alternates
//      scan start 2, but the grant stays 1.

Source files
------------

// File: rtl/exu_alu_sched.sv
// Purpose : round-robin scheduler sharing one ALU datapath among NUM_REQ issue requesters.
// Latency : 1 cycle from grant (alu_enable) to rsp_valid; 1 op/cycle when rsp_ready stays high.
// Backpr. : rsp_ready low parks the result in HOLD (no grant, ALU flops frozen); freeze stalls all.
//
// Ports:
//   clk, rst                    core clock, synchronous active-high reset
//   freeze, flush               pipeline freeze (hold everything) / flush (kill in-flight op)
//   req_valid/req_ready         per-requester handshake; req_ready is the one-hot grant
//   req_a/req_b/req_pc/req_op   per-requester payload, requester i in slice i
//   alu_valid/alu_enable        issue strobe to the ALU operand flops
//   alu_a/alu_b/alu_pc/alu_op   muxed payload of the granted requester, 0 when idle
//   alu_flush                   flush forwarded to the ALU
//   alu_out                     ALU result, valid the cycle after alu_enable
//   rsp_valid/rsp_ready         result handshake; rsp_id tags the originating requester
//   rsp_id, rsp_data            result tag and data
//   busy                        an op occupies the ALU
module exu_alu_sched #(
  parameter int NUM_REQ = 4,
  parameter int OPW     = 16,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*31-1:0]  req_pc,
  input  logic [NUM_REQ*OPW-1:0] req_op,
  output logic                   alu_valid,
  output logic                   alu_enable,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [30:0]            alu_pc,
  output logic [OPW-1:0]         alu_op,
  output logic                   alu_flush,
  input  logic [31:0]            alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [31:0]            rsp_data,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;

  logic             can_issue;
  logic             found;
  logic [IDW-1:0]   gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic             transfer;
  logic             occupied;

  assign occupied = (state_q != IDLE);

  // Rotating priority scan starting at ptr_q; the first valid requester wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  // A new op may enter only when the ALU is empty or its result leaves this cycle.
  // rst is folded in so every output is quiet while reset is asserted.
  assign can_issue = ~rst & ~flush & ~freeze & (~occupied | rsp_ready);
  assign gnt_oh    = found ? (NUM_REQ'(1) << gnt_id) : '0;
  assign req_ready = can_issue ? gnt_oh : '0;
  assign transfer  = |(req_valid & req_ready);

  assign alu_valid  = transfer;
  assign alu_enable = transfer;
  assign alu_flush  = flush & ~rst;

  // AND-OR payload mux keyed by the one-hot grant; zero when nothing issues.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_pc = '0;
    alu_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        alu_a  = alu_a  | req_a[32*i +: 32];
        alu_b  = alu_b  | req_b[32*i +: 32];
        alu_pc = alu_pc | req_pc[31*i +: 31];
        alu_op = alu_op | req_op[OPW*i +: OPW];
      end
    end
  end

  assign rsp_valid = ~rst & occupied & ~freeze & ~flush;
  assign rsp_id    = id_q;
  assign rsp_data  = alu_out;
  assign busy      = ~rst & occupied;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    if (flush) begin
      // Killed result is dropped; the scan position is left alone.
      state_d = IDLE;
    end else if (!freeze) begin
      if (transfer) begin
        state_d = EXEC;
        id_d    = gnt_id;
        ptr_d   = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        state_d = IDLE;
      end else if (rsp_valid) begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_exu_alu_sched.sv
// Purpose : self-checking bench for exu_alu_sched against a transaction-level model.
// Latency : one step() per clock; outputs sampled 1 time unit after inputs settle.
// Backpr. : stimulus keeps a requester's payload stable until the model says it was granted.
module tb_exu_alu_sched;
  localparam int NUM_REQ = 4;
  localparam int OPW     = 16;
  localparam int IDW     = 2;

  logic                   clk = 1'b0;
  logic                   rst, freeze, flush, rsp_ready;
  logic [NUM_REQ-1:0]     req_valid, req_ready;
  logic [NUM_REQ*32-1:0]  req_a, req_b;
  logic [NUM_REQ*31-1:0]  req_pc;
  logic [NUM_REQ*OPW-1:0] req_op;
  logic                   alu_valid, alu_enable, alu_flush;
  logic [31:0]            alu_a, alu_b;
  logic [30:0]            alu_pc;
  logic [OPW-1:0]         alu_op;
  logic [31:0]            alu_out = 32'h0;
  logic                   rsp_valid, busy;
  logic [IDW-1:0]         rsp_id;
  logic [31:0]            rsp_data;

  exu_alu_sched #(.NUM_REQ(NUM_REQ), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_op(req_op),
    .alu_valid(alu_valid), .alu_enable(alu_enable),
    .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc), .alu_op(alu_op),
    .alu_flush(alu_flush), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [15:0] op);
    return (a + b) ^ {op, op};
  endfunction

  // Stand-in ALU: operand flops load on alu_enable, result holds otherwise.
  always @(posedge clk) if (alu_enable) alu_out <= alu_fn(alu_a, alu_b, alu_op);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester payloads.
  logic [31:0] pa[NUM_REQ];
  logic [31:0] pb[NUM_REQ];
  logic [30:0] ppc[NUM_REQ];
  logic [15:0] pop[NUM_REQ];

  // Model: at most one result in flight, plus the round-robin start position.
  logic        m_pend = 1'b0;
  int          m_id   = 0;
  logic [31:0] m_data = 32'h0;
  int          m_ptr  = 0;
  logic [3:0]  m_last_gnt = 4'h0;

  // Observed DUT values from the latest step, for directed checks.
  logic [3:0]  obs_ready;
  logic        obs_rv, obs_en, obs_busy;
  logic [1:0]  obs_id;
  logic [31:0] obs_data;

  task automatic step(input logic r, input logic fz, input logic fl, input logic rr,
                      input logic [3:0] v);
    logic       exp_rv, can;
    int         g;
    logic [3:0] exp_rdy;
    rst = r; freeze = fz; flush = fl; rsp_ready = rr; req_valid = v;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32]   = pa[i];
      req_b[32*i +: 32]   = pb[i];
      req_pc[31*i +: 31]  = ppc[i];
      req_op[OPW*i +: OPW] = pop[i];
    end
    #1;
    exp_rv = !r && m_pend && !fz && !fl;
    can    = !r && !fl && !fz && (!m_pend || rr);
    g = -1;
    if (can) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;

    obs_ready = req_ready; obs_rv = rsp_valid; obs_en = alu_enable;
    obs_busy  = busy;      obs_id = rsp_id;    obs_data = rsp_data;

    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("alu_valid", 64'(alu_valid), 64'(g >= 0));
    chk("alu_enable", 64'(alu_enable), 64'(g >= 0));
    chk("alu_a", 64'(alu_a), (g >= 0) ? 64'(pa[g]) : 64'h0);
    chk("alu_b", 64'(alu_b), (g >= 0) ? 64'(pb[g]) : 64'h0);
    chk("alu_pc", 64'(alu_pc), (g >= 0) ? 64'(ppc[g]) : 64'h0);
    chk("alu_op", 64'(alu_op), (g >= 0) ? 64'(pop[g]) : 64'h0);
    chk("alu_flush", 64'(alu_flush), 64'(fl && !r));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("busy", 64'(busy), 64'(!r && m_pend));
    if (exp_rv) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
    end

    if (r) begin
      m_pend = 1'b0; m_ptr = 0; m_id = 0;
    end else if (fl) begin
      m_pend = 1'b0;
    end else if (!fz) begin
      if (g >= 0) begin
        m_pend = 1'b1; m_id = g;
        m_data = alu_fn(pa[g], pb[g], pop[g]);
        m_ptr  = (g + 1) % NUM_REQ;
      end else if (exp_rv && rr) begin
        m_pend = 1'b0;
      end
    end
    m_last_gnt = exp_rdy;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  vcur;
  logic [31:0] held;

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; rsp_ready = 1'b0; req_valid = '0;
    req_a = '0; req_b = '0; req_pc = '0; req_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pa[i] = 32'(i); pb[i] = 32'h100 * 32'(i + 1); ppc[i] = 31'(i + 8); pop[i] = 16'(i * 3);
    end
    @(posedge clk); #1;

    // T1: reset with everyone requesting, then grant 0 first.
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
      chk("t1_ready", 64'(obs_ready), 64'h0);
      chk("t1_rv", 64'(obs_rv), 64'h0);
      chk("t1_busy", 64'(obs_busy), 64'h0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    chk("t1_first_gnt", 64'(obs_ready), 64'h1);

    // T2: round robin 1,2,3,0 with responses trailing by one cycle.
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
      chk("t2_gnt", 64'(obs_ready), 64'(4'b0001 << (k % 4)));
      chk("t2_rsp_id", 64'(obs_id), 64'(k - 1));
      chk("t2_en", 64'(obs_en), 64'h1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);   // drain id 0, ptr now 1

    // T3: stall in HOLD with req2 waiting, then accept + grant together.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    held = obs_data;
    for (int n = 0; n < 2; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
      chk("t3_data_stable", 64'(obs_data), 64'(held));
      chk("t3_en", 64'(obs_en), 64'h0);
      chk("t3_ready", 64'(obs_ready), 64'h0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    chk("t3_accept", 64'(obs_rv), 64'h1);
    chk("t3_gnt2", 64'(obs_ready), 64'b0100);

    // T4: flush while id 1 executes; next scan starts at 2.
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    chk("t4_gnt1", 64'(obs_ready), 64'b0010);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    chk("t4_flush_rv", 64'(obs_rv), 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    chk("t4_gnt_after", 64'(obs_ready), 64'b0100);
    chk("t4_no_rsp", 64'(obs_rv), 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    chk("t4_rsp_id", 64'(obs_id), 64'h2);

    // T5: freeze over an op from requester 3 producing 0x1234.
    pa[3] = 32'h1234; pb[3] = 32'h0; pop[3] = 16'h0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    chk("t5_gnt3", 64'(obs_ready), 64'b1000);
    for (int n = 0; n < 2; n++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
      chk("t5_frz_ready", 64'(obs_ready), 64'h0);
      chk("t5_frz_rv", 64'(obs_rv), 64'h0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("t5_rv", 64'(obs_rv), 64'h1);
    chk("t5_id", 64'(obs_id), 64'h3);
    chk("t5_data", 64'(obs_data), 64'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);

    // T6: a lone requester keeps winning regardless of scan start.
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
      chk("t6_gnt1", 64'(obs_ready), 64'b0010);
    end

    // Random traffic; a requester only changes its offer once it has been granted.
    vcur = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!vcur[i] || m_last_gnt[i]) begin
          vcur[i] = ($urandom_range(0, 99) < 55);
          pa[i]   = $urandom;
          pb[i]   = $urandom;
          ppc[i]  = 31'($urandom);
          pop[i]  = 16'($urandom);
        end
      end
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 70,
           vcur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
